// File: rtl/aes_gcm_block_scheduler.sv
// rtl/aes_gcm_block_scheduler.sv - AES-GCM front-end sequencer: descriptor in, AAD/PT block slots with counter blocks out.
// Optional statistics counters are enabled by defining AES_GCM_SCHED_STATS_EN.
module aes_gcm_block_scheduler #(
    parameter int CNT_W      = 32,
    parameter int GAP_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_desc_valid,
    output logic             o_desc_ready,
    input  logic [127:0]     i_j0,
    input  logic [127:0]     i_h,
    input  logic [CNT_W-1:0] i_aad_blocks,
    input  logic [CNT_W-1:0] i_pt_blocks,
    input  logic             i_blk_valid,
    output logic             o_blk_ready,
    input  logic [127:0]     i_blk_data,
    output logic             o_valid,
    output logic [127:0]     o_plain_text,
    output logic [127:0]     o_aad,
    output logic [127:0]     o_h,
    output logic [127:0]     o_j0,
    output logic [127:0]     o_cb,
    output logic [127:0]     o_instance_size,
    output logic             o_new_instance,
    output logic             o_pt_instance,
    output logic             o_last
`ifdef AES_GCM_SCHED_STATS_EN
    ,
    output logic [31:0]      o_stat_instances,
    output logic [31:0]      o_stat_blocks
`endif
);

    typedef enum logic [2:0] {IDLE, AAD, PT, EMPTY, GAP} state_t;

    // The descriptor-accept cycle already yields one idle output slot, so the
    // GAP state only has to supply the remaining GAP_CYCLES-1 idle cycles.
    localparam int GAP_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES - 1) : 1;

    state_t           state;
    logic [CNT_W-1:0] aad_left;
    logic [CNT_W-1:0] pt_left;
    logic [31:0]      ctr;
    logic             first;
    logic [GAP_W-1:0] gap_cnt;

    logic        desc_accept;
    logic        blk_accept;
    logic [31:0] ctr_next;

    assign desc_accept = (state == IDLE) && o_desc_ready && i_desc_valid;
    assign blk_accept  = o_blk_ready && i_blk_valid;
    assign ctr_next    = ctr + 32'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            aad_left        <= '0;
            pt_left         <= '0;
            ctr             <= '0;
            first           <= 1'b0;
            gap_cnt         <= '0;
            o_desc_ready    <= 1'b0;
            o_blk_ready     <= 1'b0;
            o_valid         <= 1'b0;
            o_plain_text    <= '0;
            o_aad           <= '0;
            o_h             <= '0;
            o_j0            <= '0;
            o_cb            <= '0;
            o_instance_size <= '0;
            o_new_instance  <= 1'b0;
            o_pt_instance   <= 1'b0;
            o_last          <= 1'b0;
        end else begin
            o_valid        <= 1'b0;
            o_plain_text   <= '0;
            o_aad          <= '0;
            o_cb           <= '0;
            o_new_instance <= 1'b0;
            o_pt_instance  <= 1'b0;
            o_last         <= 1'b0;

            case (state)
                IDLE: begin
                    o_desc_ready <= 1'b1;
                    o_blk_ready  <= 1'b0;
                    if (desc_accept) begin
                        o_desc_ready    <= 1'b0;
                        o_j0            <= i_j0;
                        o_h             <= i_h;
                        o_instance_size <= {64'(i_aad_blocks) << 7, 64'(i_pt_blocks) << 7};
                        aad_left        <= i_aad_blocks;
                        pt_left         <= i_pt_blocks;
                        ctr             <= i_j0[31:0];
                        first           <= 1'b1;
                        if (i_aad_blocks != '0) begin
                            state       <= AAD;
                            o_blk_ready <= 1'b1;
                        end else if (i_pt_blocks != '0) begin
                            state       <= PT;
                            o_blk_ready <= 1'b1;
                        end else begin
                            state <= EMPTY;
                        end
                    end
                end

                AAD: begin
                    if (blk_accept) begin
                        o_valid        <= 1'b1;
                        o_aad          <= i_blk_data;
                        o_new_instance <= first;
                        first          <= 1'b0;
                        aad_left       <= aad_left - CNT_W'(1);
                        if (aad_left == CNT_W'(1)) begin
                            if (pt_left != '0) begin
                                state <= PT;
                            end else begin
                                o_last      <= 1'b1;
                                o_blk_ready <= 1'b0;
                                if (GAP_CYCLES > 1) begin
                                    state   <= GAP;
                                    gap_cnt <= '0;
                                end else begin
                                    state        <= IDLE;
                                    o_desc_ready <= 1'b1;
                                end
                            end
                        end
                    end
                end

                PT: begin
                    if (blk_accept) begin
                        o_valid        <= 1'b1;
                        o_plain_text   <= i_blk_data;
                        o_pt_instance  <= 1'b1;
                        // Only the low 32-bit field counts; it wraps without carrying upward.
                        o_cb           <= {o_j0[127:32], ctr_next};
                        ctr            <= ctr_next;
                        o_new_instance <= first;
                        first          <= 1'b0;
                        pt_left        <= pt_left - CNT_W'(1);
                        if (pt_left == CNT_W'(1)) begin
                            o_last      <= 1'b1;
                            o_blk_ready <= 1'b0;
                            if (GAP_CYCLES > 1) begin
                                state   <= GAP;
                                gap_cnt <= '0;
                            end else begin
                                state        <= IDLE;
                                o_desc_ready <= 1'b1;
                            end
                        end
                    end
                end

                EMPTY: begin
                    o_valid        <= 1'b1;
                    o_new_instance <= 1'b1;
                    o_last         <= 1'b1;
                    first          <= 1'b0;
                    if (GAP_CYCLES > 1) begin
                        state   <= GAP;
                        gap_cnt <= '0;
                    end else begin
                        state        <= IDLE;
                        o_desc_ready <= 1'b1;
                    end
                end

                GAP: begin
                    if (gap_cnt == GAP_W'(GAP_CYCLES - 2)) begin
                        state        <= IDLE;
                        o_desc_ready <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end

                default: begin
                    state        <= IDLE;
                    o_desc_ready <= 1'b0;
                    o_blk_ready  <= 1'b0;
                end
            endcase
        end
    end

`ifdef AES_GCM_SCHED_STATS_EN
    // Block statistics lag the slot by one cycle since they count registered o_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_stat_instances <= '0;
            o_stat_blocks    <= '0;
        end else begin
            if (desc_accept) begin
                o_stat_instances <= o_stat_instances + 32'd1;
            end
            if (o_valid) begin
                o_stat_blocks <= o_stat_blocks + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/aes_gcm_block_scheduler.md
Name: aes_gcm_block_scheduler

Overview:
- Front-end sequencer for the AES-GCM encrypt pipeline.
- Accepts one instance descriptor (J0, H, AAD block count, PT block count), then streams that instance's AAD blocks followed by its PT blocks into pipeline stage 1, one block per cycle.
- Per block it generates the counter block (inc32 chain from J0), the new-instance marker, the PT/AAD flag and the 128-bit instance-size word.
- The pipeline is free-running with no stall, so this block is the only flow-control point.

Parameters:
- CNT_W, 32, width of the AAD and PT block counts.
- GAP_CYCLES, 1, minimum idle cycles inserted between the last block of one instance and the first block of the next (0 allowed).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- i_desc_valid  in  1  descriptor valid.
- o_desc_ready  out  1  descriptor accepted when valid&ready.
- i_j0  in  128  pre-counter block J0 (bit 0 = MSB).
- i_h  in  128  hash subkey input block, forwarded unchanged.
- i_aad_blocks  in  CNT_W  number of 128-bit AAD blocks.
- i_pt_blocks  in  CNT_W  number of 128-bit PT blocks.
- i_blk_valid  in  1  data block valid.
- o_blk_ready  out  1  data block consumed when valid&ready.
- i_blk_data  in  128  AAD or PT block.
- o_valid  out  1  pipeline slot carries a block.
- o_plain_text  out  128  PT block (0 on AAD/empty slots).
- o_aad  out  128  AAD block (0 on PT/empty slots).
- o_h  out  128  H of current instance.
- o_j0  out  128  J0 of current instance.
- o_cb  out  128  counter block (0 on AAD/empty slots).
- o_instance_size  out  128  {len(A) bits, 64b ; len(C) bits, 64b}.
- o_new_instance  out  1  first slot of an instance.
- o_pt_instance  out  1  slot is a PT block.
- o_last  out  1  final slot of an instance.

Interface: one clock, `clk`; reset `rst` is synchronous and active-high.

Behaviour:
- States: IDLE, AAD, PT, EMPTY, GAP.
- Reset, and every cycle `rst`=1: state=IDLE; all outputs and internal registers 0.
- IDLE:
  - o_desc_ready=1.
  - On accept, latch j0, h, counts, and size = {aad_blocks*128, pt_blocks*128}, each zero-extended to 64b.
  - Next state: aad>0 → AAD; else pt>0 → PT; else EMPTY.
  - o_blk_ready=0.
- AAD / PT:
  - o_desc_ready=0; o_blk_ready=1.
  - Each accepted block is registered onto the outputs on the next cycle (latency 1). o_valid=0 in any cycle following no accept (bubble).
- AAD:
  - Output block on o_aad; o_pt_instance=0.
  - After the aad_blocks-th accept: → PT if pt>0, else → GAP with o_last on that slot.
- PT:
  - Output block on o_plain_text; o_pt_instance=1.
  - o_cb for the k-th PT block (k from 1) = J0[0:95] || (J0[96:127]+k mod 2^32). The 32-bit field wraps 0xFFFFFFFF→0x00000000 with no carry into bit 95.
  - After the pt_blocks-th accept: → GAP with o_last on that slot.
- EMPTY (aad=pt=0):
  - One slot with o_valid=1, o_new_instance=1, o_last=1, data/cb=0. No block consumed. → GAP.
- o_new_instance: 1 only on the first valid slot of an instance. o_new_instance and o_last are both 1 on a 1-block instance.
- o_h, o_j0, o_instance_size hold their values from descriptor accept until the next accept.
- GAP: counts GAP_CYCLES cycles with o_valid=0, then → IDLE. GAP_CYCLES=0 → IDLE directly; the next descriptor is accepted the cycle after o_last.
- Descriptor presented while busy: held off (ready=0), never dropped.
- i_blk_valid while IDLE/GAP/EMPTY: ignored (ready=0).
- Reset mid-instance: remaining blocks abandoned. No o_last is emitted for the aborted instance.

Optional Feature:
- Macro AES_GCM_SCHED_STATS_EN.
- Defined: adds outputs o_stat_instances (32b) and o_stat_blocks (32b).
  - o_stat_instances increments on each descriptor accept.
  - o_stat_blocks increments on each valid slot, including EMPTY.
  - Both wrap mod 2^32 and clear on rst.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- rst held 3 cycles mid-AAD stream → all outputs 0 in the cycle after the first rst cycle; state IDLE; o_desc_ready=1 after rst falls.
- Descriptor aad=2, pt=3, J0=0x...00000001, data always valid → 5 consecutive o_valid slots:
  - pt_instance = 0,0,1,1,1.
  - o_cb low words = 2,3,4.
  - new_instance on slot 1; o_last on slot 5.
  - instance_size = {64'd256, 64'd384}.
- J0 low word 0xFFFFFFFE, pt=3 → o_cb low words 0xFFFFFFFF, 0x00000000, 0x00000001; bits 0..95 unchanged.
- aad=0, pt=0 → single slot with o_valid=1, new_instance=1, last=1; o_blk_ready stays 0 throughout.
- pt=4 with i_blk_valid toggling 1,0,1,0,... → o_valid follows with 1-cycle lag. Counter increments only on accepted blocks (2,3,4,5).
- Back-to-back descriptors, GAP_CYCLES=1 → exactly one o_valid=0 cycle between o_last and the next o_new_instance. Second descriptor held until IDLE.
